sel_encode_seq: RTL and testbench

SEL_ENCODE_SEQ -- requirements
Module: sel_encode_seq

---
 rtl/sel_encode_seq.sv | 136 +++++++++++++
 tb/tb_sel_encode_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sel_encode_seq.sv
// Register-select encoder: decodes Ra/Rb/Rc from a latched instruction word into one-hot
// register-file strobes, plus a list sequencer that sweeps a register mask one register at a time.
module sel_encode_seq #(
  parameter int IR_W    = 32,
  parameter int OPC_W   = 5,
  parameter int AW      = 4,
  parameter int CONST_W = 19,
  parameter int NREGS   = 2**AW
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               ir_ld,
  input  logic [IR_W-1:0]    ir_in,
  input  logic               gra,
  input  logic               grb,
  input  logic               grc,
  input  logic               rin,
  input  logic               rout,
  input  logic               baout,
  input  logic               lst_start,
  input  logic [NREGS-1:0]   lst_mask,
  input  logic               lst_dir,
  input  logic               lst_step,
  output logic [NREGS-1:0]   r_en,
  output logic [NREGS-1:0]   r_out,
  output logic [OPC_W-1:0]   opcode,
  output logic [IR_W-1:0]    c_sign,
  output logic [IR_W-1:0]    ir_q,
  output logic               ba_zero,
  output logic               lst_busy,
  output logic               lst_done,
  output logic [AW-1:0]      lst_idx,
  output logic [1:0]         state_dbg
);

  // Handshake: in SCAN the current list register is offered every cycle; the consumer
  // accepts it by holding lst_step high for that cycle, and the register retires at the edge.

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} lst_state_t;

  lst_state_t       state, state_nxt;
  logic [NREGS-1:0] pm, pm_nxt;
  logic             dir_q, dir_nxt;

  logic [AW-1:0]    ra, rb, rc, sel_idx, low_idx;
  logic [NREGS-1:0] sel_hot, scan_hot;
  logic             ba_zero_c;

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      pm    <= '0;
      dir_q <= 1'b0;
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      pm    <= pm_nxt;
      dir_q <= dir_nxt;
      if (ir_ld) ir_q <= ir_in;
    end
  end

  assign ra = ir_q[IR_W-OPC_W-1 -: AW];
  assign rb = ir_q[IR_W-OPC_W-AW-1 -: AW];
  assign rc = ir_q[IR_W-OPC_W-2*AW-1 -: AW];

  assign opcode = ir_q[IR_W-1 -: OPC_W];
  assign c_sign = {{(IR_W-CONST_W){ir_q[CONST_W-1]}}, ir_q[CONST_W-1:0]};

  assign sel_idx   = (ra & {AW{gra}}) | (rb & {AW{grb}}) | (rc & {AW{grc}});
  assign sel_hot   = NREGS'(1) << sel_idx;
  assign ba_zero_c = baout & ~rout & (sel_idx == '0);

  // Lowest pending register is serviced first.
  always_comb begin
    low_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (pm[i]) low_idx = AW'(i);
    end
  end

  assign scan_hot = NREGS'(1) << low_idx;

  always_comb begin
    state_nxt = state;
    pm_nxt    = pm;
    dir_nxt   = dir_q;
    case (state)
      IDLE: begin
        if (lst_start) begin
          if (lst_mask != '0) begin
            pm_nxt    = lst_mask;
            dir_nxt   = lst_dir;
            state_nxt = SCAN;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      SCAN: begin
        if (lst_step) begin
          pm_nxt = pm & ~scan_hot;
          if (pm_nxt == '0) state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        pm_nxt    = '0;
      end
    endcase
  end

  always_comb begin
    r_en     = '0;
    r_out    = '0;
    ba_zero  = 1'b0;
    lst_busy = 1'b0;
    lst_idx  = '0;
    if (state == SCAN) begin
      lst_busy = 1'b1;
      lst_idx  = low_idx;
      if (dir_q) r_en  = scan_hot;
      else       r_out = scan_hot;
    end else begin
      ba_zero = ba_zero_c;
      if (rin) r_en = sel_hot;
      // Base-address read of R0 means "literal zero", so no register drives the bus.
      if ((rout | baout) && !ba_zero_c) r_out = sel_hot;
    end
  end

  assign lst_done  = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_sel_encode_seq.sv
// Bench for sel_encode_seq: directed decode/sequencer scenarios plus a random decode sweep,
// checked through a scoreboard queue of expected strobe vectors.
module tb_sel_encode_seq;

  localparam int W = 39; // {r_en[16], r_out[16], ba_zero, busy, done, idx[4]}

  logic        clock = 1'b0;
  logic        clear, ir_ld, gra, grb, grc, rin, rout, baout;
  logic        lst_start, lst_dir, lst_step;
  logic [31:0] ir_in;
  logic [15:0] lst_mask;
  logic [15:0] r_en, r_out;
  logic [4:0]  opcode;
  logic [31:0] c_sign, ir_q;
  logic        ba_zero, lst_busy, lst_done;
  logic [3:0]  lst_idx;
  logic [1:0]  state_dbg;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  sel_encode_seq dut (
    .clock(clock), .clear(clear), .ir_ld(ir_ld), .ir_in(ir_in),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .lst_start(lst_start), .lst_mask(lst_mask), .lst_dir(lst_dir), .lst_step(lst_step),
    .r_en(r_en), .r_out(r_out), .opcode(opcode), .c_sign(c_sign), .ir_q(ir_q),
    .ba_zero(ba_zero), .lst_busy(lst_busy), .lst_done(lst_done), .lst_idx(lst_idx),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input logic [15:0] en, input logic [15:0] ro,
                                      input logic bz, input logic bs, input logic dn,
                                      input logic [3:0] ix);
    return {en, ro, bz, bs, dn, ix};
  endfunction

  // Reference decode for the non-SCAN states.
  function automatic logic [W-1:0] model_dec(input logic [31:0] ir, input logic a, input logic b,
                                             input logic c, input logic wi, input logic ro,
                                             input logic ba, input logic dn);
    logic [3:0]  idx;
    logic [15:0] hot, en, rd;
    logic        bz;
    idx = (ir[26:23] & {4{a}}) | (ir[22:19] & {4{b}}) | (ir[18:15] & {4{c}});
    hot = 16'h0001 << idx;
    bz  = ba && !ro && (idx == 4'd0);
    en  = wi ? hot : 16'h0;
    rd  = ((ro || ba) && !bz) ? hot : 16'h0;
    return pk(en, rd, bz, 1'b0, dn, 4'd0);
  endfunction

  task automatic idle_inputs();
    ir_ld = 0; gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; baout = 0;
    lst_start = 0; lst_step = 0; lst_dir = 0; lst_mask = 16'h0;
  endtask

  task automatic set_sel(input logic a, input logic b, input logic c,
                         input logic wi, input logic ro, input logic ba);
    gra = a; grb = b; grc = c; rin = wi; rout = ro; baout = ba;
  endtask

  // Push the expectation for this cycle, compare at the falling edge, advance past the rising edge.
  task automatic cyc(input string tag, input logic [W-1:0] e);
    logic [W-1:0] exp_v;
    exp_q.push_back(e);
    @(negedge clock);
    exp_v = exp_q.pop_front();
    chk({tag, ".r_en"},  32'(r_en),     32'(exp_v[38:23]));
    chk({tag, ".r_out"}, 32'(r_out),    32'(exp_v[22:7]));
    chk({tag, ".ba0"},   32'(ba_zero),  32'(exp_v[6]));
    chk({tag, ".busy"},  32'(lst_busy), 32'(exp_v[5]));
    chk({tag, ".done"},  32'(lst_done), 32'(exp_v[4]));
    chk({tag, ".idx"},   32'(lst_idx),  32'(exp_v[3:0]));
    @(posedge clock);
    #1;
  endtask

  task automatic load_ir(input logic [31:0] v);
    ir_ld = 1; ir_in = v;
    @(posedge clock);
    #1;
    ir_ld = 0;
  endtask

  logic [31:0] rnd_ir;
  logic [5:0]  rnd_s;

  initial begin
    idle_inputs();
    ir_in = 32'h0;
    clear = 1;
    @(posedge clock); #1;
    // clear wins over ir_ld and lst_start
    ir_ld = 1; ir_in = 32'hFFFF_FFFF; lst_start = 1; lst_mask = 16'h00F0;
    @(posedge clock); #1;
    idle_inputs();
    clear = 0;
    chk("rst.ir_q", ir_q, 32'h0);
    chk("rst.opcode", 32'(opcode), 32'h0);
    chk("rst.c_sign", c_sign, 32'h0);
    chk("rst.state", 32'(state_dbg), 32'h0);
    cyc("rst", pk(16'h0, 16'h0, 0, 0, 0, 4'd0));

    // basic decode
    load_ir(32'h0A98_0000);
    chk("dec.opcode", 32'(opcode), 32'h01);
    set_sel(1, 0, 0, 1, 0, 0);
    cyc("dec.ra_rin", pk(16'h0020, 16'h0, 0, 0, 0, 4'd0));
    set_sel(0, 1, 0, 0, 1, 0);
    cyc("dec.rb_rout", pk(16'h0, 16'h0008, 0, 0, 0, 4'd0));
    set_sel(0, 0, 0, 1, 0, 0);
    cyc("dec.none", pk(16'h0001, 16'h0, 0, 0, 0, 4'd0));
    set_sel(1, 1, 0, 1, 0, 0);
    cyc("dec.or", pk(16'h0080, 16'h0, 0, 0, 0, 4'd0));

    // base-address zero
    load_ir(32'h0A80_0000);
    set_sel(0, 1, 0, 0, 0, 1);
    cyc("ba.r0", pk(16'h0, 16'h0, 1, 0, 0, 4'd0));
    set_sel(0, 1, 0, 0, 1, 1);
    cyc("ba.r0_rout", pk(16'h0, 16'h0001, 0, 0, 0, 4'd0));
    load_ir(32'h0AB8_0000);
    set_sel(0, 1, 0, 0, 0, 1);
    cyc("ba.r7", pk(16'h0, 16'h0080, 0, 0, 0, 4'd0));
    set_sel(0, 0, 0, 0, 0, 0);

    // sign extension
    load_ir(32'h0004_0001);
    chk("csign.neg", c_sign, 32'hFFFC_0001);
    load_ir(32'h0003_FFFF);
    chk("csign.pos", c_sign, 32'h0003_FFFF);

    // random decode sweep
    for (int i = 0; i < 24; i++) begin
      rnd_ir = $urandom;
      rnd_s  = 6'($urandom_range(0, 63));
      load_ir(rnd_ir);
      chk("rnd.opcode", 32'(opcode), 32'(rnd_ir[31:27]));
      chk("rnd.c_sign", c_sign, {{13{rnd_ir[18]}}, rnd_ir[18:0]});
      set_sel(rnd_s[0], rnd_s[1], rnd_s[2], rnd_s[3], rnd_s[4], rnd_s[5]);
      cyc("rnd", model_dec(rnd_ir, rnd_s[0], rnd_s[1], rnd_s[2], rnd_s[3], rnd_s[4], rnd_s[5], 0));
      set_sel(0, 0, 0, 0, 0, 0);
    end

    // read sweep, step always high
    load_ir(32'h0A98_0000);
    lst_start = 1; lst_mask = 16'h8011; lst_dir = 0; lst_step = 1;
    cyc("rd.start", pk(16'h0, 16'h0, 0, 0, 0, 4'd0));
    lst_start = 0; lst_mask = 16'h0;
    cyc("rd.i0", pk(16'h0, 16'h0001, 0, 1, 0, 4'd0));
    cyc("rd.i4", pk(16'h0, 16'h0010, 0, 1, 0, 4'd4));
    cyc("rd.i15", pk(16'h0, 16'h8000, 0, 1, 0, 4'd15));
    cyc("rd.done", pk(16'h0, 16'h0, 0, 0, 1, 4'd0));
    cyc("rd.idle", pk(16'h0, 16'h0, 0, 0, 0, 4'd0));

    // write sweep with stalls; selects and lst_start ignored in SCAN
    lst_start = 1; lst_mask = 16'h8011; lst_dir = 1; lst_step = 1;
    cyc("wr.start", pk(16'h0, 16'h0, 0, 0, 0, 4'd0));
    lst_start = 0; lst_dir = 0;
    set_sel(1, 0, 0, 1, 1, 0);
    cyc("wr.i0", pk(16'h0001, 16'h0, 0, 1, 0, 4'd0));
    lst_step = 0; lst_start = 1; lst_mask = 16'h0002;
    cyc("wr.i4a", pk(16'h0010, 16'h0, 0, 1, 0, 4'd4));
    cyc("wr.i4b", pk(16'h0010, 16'h0, 0, 1, 0, 4'd4));
    lst_step = 1; lst_start = 0; lst_mask = 16'h0;
    cyc("wr.i4c", pk(16'h0010, 16'h0, 0, 1, 0, 4'd4));
    cyc("wr.i15", pk(16'h8000, 16'h0, 0, 1, 0, 4'd15));
    set_sel(1, 0, 0, 1, 0, 0);
    cyc("wr.done", model_dec(32'h0A98_0000, 1, 0, 0, 1, 0, 0, 1));
    set_sel(0, 0, 0, 0, 0, 0);
    cyc("wr.idle", pk(16'h0, 16'h0, 0, 0, 0, 4'd0));

    // empty mask
    lst_start = 1; lst_mask = 16'h0;
    cyc("empty.start", pk(16'h0, 16'h0, 0, 0, 0, 4'd0));
    lst_start = 0;
    cyc("empty.done", pk(16'h0, 16'h0, 0, 0, 1, 4'd0));
    cyc("empty.idle", pk(16'h0, 16'h0, 0, 0, 0, 4'd0));

    // clear mid-SCAN
    lst_start = 1; lst_mask = 16'h00FF; lst_dir = 1; lst_step = 1;
    cyc("abort.start", pk(16'h0, 16'h0, 0, 0, 0, 4'd0));
    lst_start = 0; lst_mask = 16'h0;
    cyc("abort.i0", pk(16'h0001, 16'h0, 0, 1, 0, 4'd0));
    clear = 1;
    cyc("abort.i1", pk(16'h0002, 16'h0, 0, 1, 0, 4'd1));
    clear = 0;
    chk("abort.ir_q", ir_q, 32'h0);
    cyc("abort.idle", pk(16'h0, 16'h0, 0, 0, 0, 4'd0));
    cyc("abort.nodone", pk(16'h0, 16'h0, 0, 0, 0, 4'd0));

    // ir_ld during SCAN
    lst_start = 1; lst_mask = 16'h0C00; lst_dir = 0; lst_step = 0;
    cyc("ldscan.start", pk(16'h0, 16'h0, 0, 0, 0, 4'd0));
    lst_start = 0;
    load_ir(32'h1234_5678);
    chk("ldscan.ir_q", ir_q, 32'h1234_5678);
    lst_step = 1;
    cyc("ldscan.i10", pk(16'h0, 16'h0400, 0, 1, 0, 4'd10));
    cyc("ldscan.i11", pk(16'h0, 16'h0800, 0, 1, 0, 4'd11));
    lst_step = 0;
    cyc("ldscan.done", pk(16'h0, 16'h0, 0, 0, 1, 4'd0));

    if (exp_q.size() != 0) chk("sb.empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
